la_frame_receiver: RTL and testbench

Host-side/loopback parser for the analyzer's UART capture frame: 0x55 0xAA LEN_L LEN_H TRIG_L TRIG_H, then LEN payload bytes.
- Consumes a byte stream from a UART RX byte interface (rx_valid/rx_data).
- Validates the header, then emits payload bytes with their sample address.
- Reports frame completion or error.
- Sits behind the UART RX deserializer in the loopback/self-check build and in the bench-side model of the capture link.

---
 rtl/la_frame_receiver_pkg.sv | 22 ++
 rtl/la_frame_receiver.sv | 154 +++++++++++++++
 tb/tb_la_frame_receiver.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/la_frame_receiver_pkg.sv
// rtl/la_frame_receiver_pkg.sv - shared capture-frame constants and parser state encoding
// Contents:
//   FRAME_SYNC0/FRAME_SYNC1  sync bytes that open every capture frame
//   FRAME_HDR_BYTES          header size: two sync bytes, LEN (LE16), TRIG (LE16)
//   rx_state_t               parser states, one per header byte plus payload
package la_frame_receiver_pkg;

    localparam logic [7:0] FRAME_SYNC0     = 8'h55;
    localparam logic [7:0] FRAME_SYNC1     = 8'hAA;
    localparam int         FRAME_HDR_BYTES = 6;

    typedef enum logic [2:0] {
        ST_SYNC0   = 3'd0,
        ST_SYNC1   = 3'd1,
        ST_LEN_L   = 3'd2,
        ST_LEN_H   = 3'd3,
        ST_TRIG_L  = 3'd4,
        ST_TRIG_H  = 3'd5,
        ST_PAYLOAD = 3'd6
    } rx_state_t;

endpackage

// File: rtl/la_frame_receiver.sv
// rtl/la_frame_receiver.sv - UART capture frame parser (sync, header check, payload, timeout)
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   rx_valid, rx_data       received byte strobe and value
//   pl_valid/pl_data/pl_addr/pl_last  payload byte stream with sample index
//   frame_done              pulse with the final payload byte
//   frame_len, trig_idx     LEN and TRIG of the last accepted header
//   busy                    parser is inside a frame (not hunting for sync)
//   hdr_err, timeout_err    error pulses; err_cnt counts them, saturating at 255
module la_frame_receiver
    import la_frame_receiver_pkg::*;
#(
    parameter int MAX_LEN     = 2048,
    parameter int ADDR_W      = 11,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              pl_valid,
    output logic [7:0]        pl_data,
    output logic [ADDR_W-1:0] pl_addr,
    output logic              pl_last,
    output logic              frame_done,
    output logic [15:0]       frame_len,
    output logic [15:0]       trig_idx,
    output logic              busy,
    output logic              hdr_err,
    output logic              timeout_err,
    output logic [7:0]        err_cnt
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    rx_state_t       state, state_nxt;
    logic [15:0]     len_r;
    logic [7:0]      trig_lo;
    logic [15:0]     trig_full;
    logic [15:0]     cnt;
    logic [TO_W-1:0] to_cnt;

    logic pl_fire;
    logic last_fire;
    logic hdr_ok;
    logic hdr_bad;
    logic to_fire;

    // TRIG is complete only while its high byte is on rx_data
    assign trig_full = {rx_data, trig_lo};
    assign busy      = (state != ST_SYNC0);

    always_comb begin
        state_nxt = state;
        pl_fire   = 1'b0;
        last_fire = 1'b0;
        hdr_ok    = 1'b0;
        hdr_bad   = 1'b0;
        to_fire   = 1'b0;
        if (rx_valid) begin
            case (state)
                ST_SYNC0: begin
                    if (rx_data == FRAME_SYNC0) state_nxt = ST_SYNC1;
                end
                ST_SYNC1: begin
                    // a repeated 0x55 may be the real start of the frame
                    if (rx_data == FRAME_SYNC1)      state_nxt = ST_LEN_L;
                    else if (rx_data == FRAME_SYNC0) state_nxt = ST_SYNC1;
                    else                             state_nxt = ST_SYNC0;
                end
                ST_LEN_L:  state_nxt = ST_LEN_H;
                ST_LEN_H:  state_nxt = ST_TRIG_L;
                ST_TRIG_L: state_nxt = ST_TRIG_H;
                ST_TRIG_H: begin
                    if (len_r == 16'd0 || len_r > 16'(MAX_LEN) || trig_full >= len_r) begin
                        hdr_bad   = 1'b1;
                        state_nxt = ST_SYNC0;
                    end else begin
                        hdr_ok    = 1'b1;
                        state_nxt = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    pl_fire = 1'b1;
                    if (cnt == len_r - 16'd1) begin
                        last_fire = 1'b1;
                        state_nxt = ST_SYNC0;
                    end
                end
                default: state_nxt = ST_SYNC0;
            endcase
        end else if (state != ST_SYNC0 && to_cnt == TO_LAST) begin
            // a byte landing in this same cycle takes the branch above instead
            to_fire   = 1'b1;
            state_nxt = ST_SYNC0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= ST_SYNC0;
            len_r       <= '0;
            trig_lo     <= '0;
            cnt         <= '0;
            to_cnt      <= '0;
            pl_valid    <= 1'b0;
            pl_data     <= '0;
            pl_addr     <= '0;
            pl_last     <= 1'b0;
            frame_done  <= 1'b0;
            frame_len   <= '0;
            trig_idx    <= '0;
            hdr_err     <= 1'b0;
            timeout_err <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state <= state_nxt;

            if (rx_valid || state == ST_SYNC0) to_cnt <= '0;
            else                               to_cnt <= to_cnt + 1'b1;

            if (rx_valid) begin
                case (state)
                    ST_LEN_L:  len_r[7:0]  <= rx_data;
                    ST_LEN_H:  len_r[15:8] <= rx_data;
                    ST_TRIG_L: trig_lo     <= rx_data;
                    default: ;
                endcase
            end

            if (hdr_ok) begin
                frame_len <= len_r;
                trig_idx  <= trig_full;
                cnt       <= '0;
            end else if (pl_fire) begin
                cnt <= cnt + 16'd1;
            end

            pl_valid <= pl_fire;
            if (pl_fire) begin
                pl_data <= rx_data;
                pl_addr <= cnt[ADDR_W-1:0];
            end
            pl_last     <= last_fire;
            frame_done  <= last_fire;
            hdr_err     <= hdr_bad;
            timeout_err <= to_fire;

            if ((hdr_bad || to_fire) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_la_frame_receiver.sv
// tb/tb_la_frame_receiver.sv - self-checking bench for la_frame_receiver
module tb_la_frame_receiver;
    import la_frame_receiver_pkg::*;

    localparam int MAX_LEN = 2048;
    localparam int ADDR_W  = 11;
    localparam int TO      = 200;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              pl_valid;
    logic [7:0]        pl_data;
    logic [ADDR_W-1:0] pl_addr;
    logic              pl_last;
    logic              frame_done;
    logic [15:0]       frame_len;
    logic [15:0]       trig_idx;
    logic              busy;
    logic              hdr_err;
    logic              timeout_err;
    logic [7:0]        err_cnt;

    la_frame_receiver #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .pl_valid(pl_valid), .pl_data(pl_data), .pl_addr(pl_addr), .pl_last(pl_last),
        .frame_done(frame_done), .frame_len(frame_len), .trig_idx(trig_idx), .busy(busy),
        .hdr_err(hdr_err), .timeout_err(timeout_err), .err_cnt(err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: header bytes collected so far, payload position, idle gap
    logic [7:0] hdr_q[$];
    bit         in_pay;
    int         m_len, m_trig, m_idx, m_gap;
    int         e_frame_len, e_trig, e_err_cnt;
    bit         e_pl_valid, e_pl_last, e_done, e_hdr_err, e_to_err;
    int         e_pl_data, e_pl_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_busy();
        return in_pay || (hdr_q.size() > 0);
    endfunction

    task automatic model_reset();
        hdr_q.delete();
        in_pay = 0; m_len = 0; m_trig = 0; m_idx = 0; m_gap = 0;
        e_frame_len = 0; e_trig = 0; e_err_cnt = 0;
        e_pl_valid = 0; e_pl_last = 0; e_done = 0; e_hdr_err = 0; e_to_err = 0;
        e_pl_data = 0; e_pl_addr = 0;
    endtask

    task automatic clear_pulses();
        e_pl_valid = 0; e_pl_last = 0; e_done = 0; e_hdr_err = 0; e_to_err = 0;
    endtask

    task automatic bump_err();
        if (e_err_cnt < 255) e_err_cnt++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int l, t;
        clear_pulses();
        m_gap = 0;
        if (in_pay) begin
            e_pl_valid = 1; e_pl_data = b; e_pl_addr = m_idx;
            if (m_idx == m_len - 1) begin
                e_pl_last = 1; e_done = 1; in_pay = 0;
            end
            m_idx++;
        end else begin
            hdr_q.push_back(b);
            if (hdr_q.size() == 1 && hdr_q[0] != FRAME_SYNC0) begin
                hdr_q.delete();
            end else if (hdr_q.size() == 2 && hdr_q[1] != FRAME_SYNC1) begin
                if (hdr_q[1] == FRAME_SYNC0) void'(hdr_q.pop_front());
                else hdr_q.delete();
            end else if (hdr_q.size() == FRAME_HDR_BYTES) begin
                l = int'(hdr_q[2]) + 256 * int'(hdr_q[3]);
                t = int'(hdr_q[4]) + 256 * int'(hdr_q[5]);
                if (l == 0 || l > MAX_LEN || t >= l) begin
                    e_hdr_err = 1; bump_err();
                end else begin
                    m_len = l; m_trig = t; e_frame_len = l; e_trig = t;
                    in_pay = 1; m_idx = 0;
                end
                hdr_q.delete();
            end
        end
    endtask

    task automatic model_idle();
        clear_pulses();
        if (m_busy()) begin
            m_gap++;
            if (m_gap == TO) begin
                e_to_err = 1; bump_err();
                hdr_q.delete(); in_pay = 0; m_gap = 0;
            end
        end else begin
            m_gap = 0;
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".pl_valid"}, 32'(pl_valid), 32'(e_pl_valid));
        if (e_pl_valid) begin
            chk({ctx, ".pl_data"}, 32'(pl_data), 32'(e_pl_data));
            chk({ctx, ".pl_addr"}, 32'(pl_addr), 32'(e_pl_addr));
        end
        chk({ctx, ".pl_last"},     32'(pl_last),     32'(e_pl_last));
        chk({ctx, ".frame_done"},  32'(frame_done),  32'(e_done));
        chk({ctx, ".hdr_err"},     32'(hdr_err),     32'(e_hdr_err));
        chk({ctx, ".timeout_err"}, 32'(timeout_err), 32'(e_to_err));
        chk({ctx, ".err_cnt"},     32'(err_cnt),     32'(e_err_cnt));
        chk({ctx, ".busy"},        32'(busy),        32'(m_busy()));
        chk({ctx, ".frame_len"},   32'(frame_len),   32'(e_frame_len));
        chk({ctx, ".trig_idx"},    32'(trig_idx),    32'(e_trig));
    endtask

    task automatic send_byte(input string ctx, input logic [7:0] b);
        @(negedge sys_clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge sys_clk);
        model_byte(b);
        #1;
        check_all(ctx);
    endtask

    task automatic idle(input string ctx, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            rx_valid = 1'b0;
            @(posedge sys_clk);
            model_idle();
            #1;
            check_all(ctx);
        end
    endtask

    task automatic send_hdr(input string ctx, input int l, input int t);
        send_byte(ctx, 8'h55);
        send_byte(ctx, 8'hAA);
        send_byte(ctx, 8'(l));
        send_byte(ctx, 8'(l >> 8));
        send_byte(ctx, 8'(t));
        send_byte(ctx, 8'(t >> 8));
    endtask

    task automatic check_zero(input string ctx);
        chk({ctx, ".pl_valid"},    32'(pl_valid),    32'd0);
        chk({ctx, ".pl_data"},     32'(pl_data),     32'd0);
        chk({ctx, ".pl_addr"},     32'(pl_addr),     32'd0);
        chk({ctx, ".pl_last"},     32'(pl_last),     32'd0);
        chk({ctx, ".frame_done"},  32'(frame_done),  32'd0);
        chk({ctx, ".frame_len"},   32'(frame_len),   32'd0);
        chk({ctx, ".trig_idx"},    32'(trig_idx),    32'd0);
        chk({ctx, ".busy"},        32'(busy),        32'd0);
        chk({ctx, ".hdr_err"},     32'(hdr_err),     32'd0);
        chk({ctx, ".timeout_err"}, 32'(timeout_err), 32'd0);
        chk({ctx, ".err_cnt"},     32'(err_cnt),     32'd0);
    endtask

    initial begin
        logic [7:0] resync[12];
        int l, t, kind;

        sys_rst  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        check_zero("reset");
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // 1. nominal maximum-length frame, back-to-back
        send_hdr("nom_hdr", 2048, 1024);
        for (int i = 0; i < 2048; i++) send_byte("nom_pl", 8'(i));
        idle("nom_idle", 3);

        // 2. resync on repeated 0x55 and garbage lead-in
        resync = '{8'h12, 8'h55, 8'h55, 8'hAA, 8'h04, 8'h00, 8'h01, 8'h00,
                   8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 12; i++) send_byte("resync", resync[i]);
        idle("resync_idle", 2);

        // 3. header errors
        send_hdr("hdr_len0", 0, 0);
        idle("hdr_len0_idle", 1);
        send_hdr("hdr_lenbig", 16'h0801, 0);
        idle("hdr_lenbig_idle", 1);
        send_hdr("hdr_trig", 4, 4);
        idle("hdr_trig_idle", 1);

        // 4. inter-byte timeout drops a partial frame, next frame is fine
        send_hdr("to_hdr", 8, 2);
        for (int i = 0; i < 3; i++) send_byte("to_pl", 8'($urandom));
        idle("to_idle", TO);
        send_hdr("to_next_hdr", 5, 4);
        for (int i = 0; i < 5; i++) send_byte("to_next_pl", 8'($urandom));
        idle("to_next_idle", 2);

        // 5. byte in the terminal timeout cycle is accepted
        send_hdr("tob_hdr", 4, 0);
        send_byte("tob_pl", 8'h11);
        idle("tob_gap", TO - 1);
        send_byte("tob_edge", 8'h22);
        idle("tob_gap2", TO - 1);
        send_byte("tob_edge2", 8'h33);
        send_byte("tob_last", 8'h44);
        idle("tob_idle", 2);

        // 6. reset in the middle of a payload
        send_hdr("rst_hdr", 10, 3);
        for (int i = 0; i < 4; i++) send_byte("rst_pl", 8'(i + 8'h80));
        @(negedge sys_clk);
        rx_valid = 1'b0;
        #2;
        sys_rst = 1'b1;
        #1;
        check_zero("midrst");
        model_reset();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        send_hdr("rst_next_hdr", 6, 5);
        for (int i = 0; i < 6; i++) send_byte("rst_next_pl", 8'($urandom));
        idle("rst_next_idle", 2);

        // randomized frames, bad headers and junk, with short random gaps
        for (int n = 0; n < 24; n++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                send_byte("rnd_junk", 8'($urandom));
                idle("rnd_gap", $urandom_range(0, 2));
            end
            kind = $urandom_range(0, 3);
            l = $urandom_range(1, 40);
            t = $urandom_range(0, l - 1);
            if (kind == 1) t = l + $urandom_range(0, 3);
            if (kind == 2) l = (n % 2 == 0) ? 0 : MAX_LEN + 1 + $urandom_range(0, 100);
            send_hdr("rnd_hdr", l, t);
            if (in_pay) begin
                while (in_pay) begin
                    send_byte("rnd_pl", 8'($urandom));
                    idle("rnd_gap", $urandom_range(0, 2));
                end
            end
            idle("rnd_idle", 1);
            if (m_busy()) idle("rnd_flush", TO);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
